pe_row_sched: RTL and testbench

PE_ROW_SCHED -- requirements
Module: pe_row_sched

---
 rtl/pe_row_sched_pkg.sv | 22 ++
 rtl/pe_row_sched_if.sv | 24 ++
 rtl/pe_row_sched_result_slot.sv | 30 +++
 rtl/pe_row_sched.sv | 134 +++++++++++++
 tb/tb_pe_row_sched.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_row_sched_pkg.sv
// Shared definitions for the PE row scheduler.
// Holds the scheduler state encoding, the PE phase constants and the
// pixel/partial-sum widths used by the scheduler, its interface and the
// result slot.
package pe_row_sched_pkg;

    localparam int PIX_W  = 24;
    localparam int PSUM_W = 20;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_row_sched_if.sv
// Pixel and result streams of the PE row scheduler.
//   pix_valid/pix_ready/pix_data : pixel stream {ch0, ch1, ch2}, 8 bits each
//   out_valid/out_ready/out_psum : result stream, one signed psum per pixel
// master = producer of pixels / consumer of results, slave = scheduler.
interface pe_row_sched_if;
    import pe_row_sched_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_psum;

    modport master (
        output pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_psum
    );

    modport slave (
        input  pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_psum
    );
endinterface

// File: rtl/pe_row_sched_result_slot.sv
// Single-entry result holding register.
//   clk, rst_n    : clock, async active-low reset
//   load, din     : capture din and raise out_valid
//   out_valid/out_ready/out_psum : result held until handshake
// A load in the same cycle as a handshake replaces the old result.
module pe_result_slot
    import pe_row_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [PSUM_W-1:0] din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PSUM_W-1:0] out_psum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_psum  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_psum  <= din;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_row_sched.sv
// Scheduler for a chain of NUM_PE processing elements.
// Feeds one pixel per three-phase group into the head PE, tracks which
// groups carried real pixels and collects the tail PE's psum into the
// result stream. The chain stalls while a result is waiting.
//   clk, rst_n            : clock, async active-low reset
//   start, cfg_len, cfg_bias : run request and its configuration
//   pe_en, pe_ifmap, pe_psum_head, pe_phase : drive of the PE chain
//   psum_tail             : psum output of the last PE
//   busy, done            : run status, done is a one-cycle pulse
//   bus                   : pixel and result streams
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for the next pixel
// MAC   | three enabled phases on the current pixel
// DRAIN | bubbles push the last pixels out of the chain
// DONE  | one-cycle completion pulse
module pe_row_sched
    import pe_row_sched_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [PSUM_W-1:0] cfg_bias,
    output logic              pe_en,
    output logic [PIX_W-1:0]  pe_ifmap,
    output logic [PSUM_W-1:0] pe_psum_head,
    output logic [1:0]        pe_phase,
    input  logic [PSUM_W-1:0] psum_tail,
    output logic              busy,
    output logic              done,
    pe_row_sched_if.slave     bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [NUM_PE-1:0]   vpipe_q, vpipe_d;
    logic [PIX_W-1:0]    pix_q;
    logic [PSUM_W-1:0]   bias_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                stall;
    logic                grp_done;
    logic                pix_acc;
    logic                capture;

    assign stall    = bus.out_valid && !bus.out_ready;
    assign pe_en    = ((state_q == MAC) || (state_q == DRAIN)) && !stall;
    assign grp_done = pe_en && (phase_q == PH_2);
    assign pix_acc  = (state_q == LOAD) && bus.pix_valid;
    assign capture  = grp_done && vpipe_q[NUM_PE-1];

    assign bus.pix_ready = (state_q == LOAD);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign pe_ifmap      = (state_q == DRAIN) ? '0 : pix_q;
    assign pe_psum_head  = bias_q;
    assign pe_phase      = phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (cfg_len == '0) ? DONE : LOAD;
            LOAD:    if (bus.pix_valid) state_d = MAC;
            MAC:     if (grp_done) state_d = (cnt_q != '0) ? LOAD : DRAIN;
            DRAIN:   if ((vpipe_q == '0) && !bus.out_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        // The last result can be accepted mid-group while DRAIN still
        // enables the chain; realign so the next run starts on phase 0.
        if (state_q == DONE) begin
            phase_d = PH_0;
        end else if (pe_en) begin
            case (phase_q)
                PH_0:    phase_d = PH_1;
                PH_1:    phase_d = PH_2;
                default: phase_d = PH_0;
            endcase
        end

        // Bit 0 marks a real pixel entering the head PE this group.
        vpipe_d = vpipe_q;
        if (grp_done) begin
            vpipe_d    = vpipe_q << 1;
            vpipe_d[0] = (state_q == MAC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_0;
            vpipe_q <= '0;
            pix_q   <= '0;
            bias_q  <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            vpipe_q <= vpipe_d;
            if (pix_acc) pix_q <= bus.pix_data;
            if ((state_q == IDLE) && start) begin
                bias_q <= cfg_bias;
                cnt_q  <= cfg_len;
            end else if (pix_acc && (cnt_q != '0)) begin
                cnt_q <= cnt_q - LEN_ONE;
            end
        end
    end

    pe_result_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .din       (psum_tail),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_psum  (bus.out_psum)
    );

endmodule

// File: tb/tb_pe_row_sched.sv
module tb_pe_row_sched;
    import pe_row_sched_pkg::*;

    localparam int NUM_PE = 4;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [19:0]       cfg_bias = '0;
    logic              pe_en;
    logic [23:0]       pe_ifmap;
    logic [19:0]       pe_psum_head;
    logic [1:0]        pe_phase;
    logic [19:0]       psum_tail;
    logic              busy;
    logic              done;

    pe_row_sched_if bus();

    pe_row_sched #(.NUM_PE(NUM_PE), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_bias     (cfg_bias),
        .pe_en        (pe_en),
        .pe_ifmap     (pe_ifmap),
        .pe_psum_head (pe_psum_head),
        .pe_phase     (pe_phase),
        .psum_tail    (psum_tail),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // PE chain plant: every PE has all filter weights 1 and adds channel
    // <phase> of its ifmap per enabled cycle; phase 2 publishes psum/ifmap.
    logic [23:0] pe_if_r [NUM_PE];
    logic [19:0] pe_ps_r [NUM_PE];
    logic [19:0] pe_acc  [NUM_PE];
    logic [23:0] m_ifm;
    logic [19:0] m_ps, m_a;

    initial begin
        for (int k = 0; k < NUM_PE; k++) begin
            pe_if_r[k] = '0;
            pe_ps_r[k] = '0;
            pe_acc[k]  = '0;
        end
    end

    always @(posedge clk) begin
        if (pe_en) begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (k == 0) begin
                    m_ifm = pe_ifmap;
                    m_ps  = pe_psum_head;
                end else begin
                    m_ifm = pe_if_r[k-1];
                    m_ps  = pe_ps_r[k-1];
                end
                m_a = ((pe_phase == 2'd0) ? m_ps : pe_acc[k])
                      + 20'(m_ifm[8*(2-int'(pe_phase)) +: 8]);
                pe_acc[k] <= m_a;
                if (pe_phase == 2'd2) begin
                    pe_ps_r[k] <= m_a;
                    pe_if_r[k] <= m_ifm;
                end
            end
        end
    end
    assign psum_tail = pe_ps_r[NUM_PE-1];

    // Reference model: each PE adds the channel sum once.
    function automatic logic [19:0] ref_psum(input logic [19:0] bias, input logic [23:0] px);
        int s;
        s = int'(px[23:16]) + int'(px[15:8]) + int'(px[7:0]);
        return bias + 20'(NUM_PE * s);
    endfunction

    // Monitor, sampled on the falling edge.
    logic [19:0] got_q[$];
    int          lat_q[$];
    int          done_cnt = 0, grp_cnt = 0, inv_err = 0, lat_err = 0, lat_g;
    logic        prev_valid = 0, prev_hs = 0, prev_stall = 0;
    logic [19:0] prev_psum = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            lat_q.delete();
            prev_valid = 0; prev_hs = 0; prev_stall = 0;
        end else begin
            if (done) done_cnt++;
            if (bus.out_valid && (!prev_valid || prev_hs)) begin
                if (lat_q.size() == 0) lat_err++;
                else begin
                    lat_g = lat_q.pop_front();
                    if (grp_cnt != lat_g + NUM_PE) lat_err++;
                end
            end
            if (bus.pix_valid && bus.pix_ready) lat_q.push_back(grp_cnt + 1);
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_psum);
            if (pe_en && bus.pix_ready) inv_err++;
            if (pe_en && bus.out_valid && !bus.out_ready) inv_err++;
            if (!busy && pe_en) inv_err++;
            if (prev_stall && (!bus.out_valid || bus.out_psum != prev_psum)) inv_err++;
            if (pe_en && pe_phase == 2'd2) grp_cnt++;
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_psum  = bus.out_psum;
        end
    end

    // Result sink: 0 = always ready, 1 = random, 2 = driven by the test.
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      bus.out_ready = 1'b1;
            else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    logic [23:0] pix_tab[$];

    task automatic send_pix(input logic [23:0] d, output bit ok);
        ok = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.pix_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 24'($urandom);
    endtask

    task automatic run_job(input logic [19:0] bias, input int gap, input bit poke_start,
                           output bit tmo, output int done_delta);
        bit ok;
        int d0;
        tmo = 0;
        got_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = LEN_W'(pix_tab.size()); cfg_bias = bias;
        @(posedge clk); #1;
        start = 1'b0; cfg_len = LEN_W'($urandom); cfg_bias = 20'($urandom);
        for (int i = 0; i < pix_tab.size(); i++) begin
            send_pix(pix_tab[i], ok);
            if (!ok) tmo = 1;
            if (poke_start && i == 0) begin
                start = 1'b1; cfg_len = 8'd7; cfg_bias = 20'd123;
                @(posedge clk); #1;
                start = 1'b0;
            end
            repeat (gap) begin @(posedge clk); #1; end
        end
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
        if (done_cnt == d0) tmo = 1;
        repeat (3) @(negedge clk);
        done_delta = done_cnt - d0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, pe_en, bus.pix_ready, bus.out_valid, done, pe_phase, pe_psum_head, pe_ifmap, bus.out_psum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b en=%b rdy=%b ov=%b done=%b ph=%0d head=%h ifm=%h psum=%h expected all 0",
                     busy, pe_en, bus.pix_ready, bus.out_valid, done, pe_phase, pe_psum_head, pe_ifmap, bus.out_psum);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, pe_en, done, bus.out_valid} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b en=%b done=%b ov=%b expected 0", busy, pe_en, done, bus.out_valid);
        end
    endtask

    task automatic test_single();
        bit tmo; int dd;
        pix_tab = '{24'h010203};
        run_job(20'd0, 0, 0, tmo, dd);
        checks++;
        if (tmo || dd != 1) begin
            errors++; $display("FAIL single_done tmo=%0d done_pulses=%0d expected 0/1", tmo, dd);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 20'd24) begin
            errors++; $display("FAIL single_result count=%0d first=%0d expected 1 result of 24",
                               got_q.size(), (got_q.size() > 0) ? int'(got_q[0]) : -1);
        end
    endtask

    task automatic test_bias_seq();
        bit tmo; int dd;
        logic [19:0] exp_v[3];
        exp_v = '{20'd7, 20'd19, 20'hFFFFB};
        pix_tab = '{24'h010101, 24'h020202, 24'h000000};
        run_job(20'hFFFFB, 0, 0, tmo, dd);
        checks++;
        if (tmo || dd != 1 || got_q.size() != 3) begin
            errors++; $display("FAIL bias_seq_count tmo=%0d done=%0d count=%0d expected 0/1/3", tmo, dd, got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_v[i]) begin
                errors++; $display("FAIL bias_seq_result[%0d] got %h expected %h", i,
                                   (i < got_q.size()) ? got_q[i] : 20'hxxxxx, exp_v[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit tmo; int dd; bit seen; int bad;
        logic [1:0] ph_s; logic [19:0] ps_s;
        seen = 0; bad = 0;
        pix_tab.delete();
        repeat (3) pix_tab.push_back(24'($urandom));
        rdy_mode = 2;
        bus.out_ready = 1'b0;
        fork
            run_job(20'h00010, 0, 0, tmo, dd);
            begin
                for (int c = 0; c < 2000 && !seen; c++) begin
                    @(negedge clk);
                    if (bus.out_valid) seen = 1;
                end
                ph_s = pe_phase; ps_s = bus.out_psum;
                repeat (10) begin
                    @(negedge clk);
                    if (pe_en !== 1'b0 || pe_phase !== ph_s || bus.out_psum !== ps_s || bus.out_valid !== 1'b1) bad++;
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                rdy_mode = 0;
            end
        join
        checks++;
        if (!seen || bad != 0) begin
            errors++; $display("FAIL stall_freeze seen=%0d frozen_violations=%0d expected 1/0", seen, bad);
        end
        checks++;
        if (tmo || dd != 1 || got_q.size() != 3) begin
            errors++; $display("FAIL stall_count tmo=%0d done=%0d count=%0d expected 0/1/3", tmo, dd, got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_psum(20'h00010, pix_tab[i])) begin
                errors++; $display("FAIL stall_result[%0d] got %h expected %h", i, got_q[i], ref_psum(20'h00010, pix_tab[i]));
            end
        end
    endtask

    task automatic test_gaps();
        bit tmo; int dd; logic [19:0] b; int e0;
        b = 20'($urandom);
        e0 = inv_err;
        pix_tab.delete();
        repeat (4) pix_tab.push_back(24'($urandom));
        run_job(b, 5, 0, tmo, dd);
        checks++;
        if (tmo || dd != 1 || got_q.size() != 4 || inv_err != e0) begin
            errors++; $display("FAIL gaps_run tmo=%0d done=%0d count=%0d en_violations=%0d expected 0/1/4/0",
                               tmo, dd, got_q.size(), inv_err - e0);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_psum(b, pix_tab[i])) begin
                errors++; $display("FAIL gaps_result[%0d] got %h expected %h", i, got_q[i], ref_psum(b, pix_tab[i]));
            end
        end
    endtask

    task automatic test_zero_len();
        bit tmo; int dd; logic [19:0] b;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = '0; cfg_bias = 20'h12345;
        @(posedge clk); #1;
        start = 1'b0; cfg_bias = '0;
        @(negedge clk);
        checks++;
        if ({busy, done, bus.out_valid} !== 3'b110) begin
            errors++; $display("FAIL zero_len_done busy=%b done=%b ov=%b expected 1/1/0", busy, done, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, bus.out_valid} !== 3'b000 || pe_psum_head !== 20'h12345) begin
            errors++; $display("FAIL zero_len_idle busy=%b done=%b ov=%b head=%h expected 0/0/0/12345",
                               busy, done, bus.out_valid, pe_psum_head);
        end
        b = 20'($urandom);
        pix_tab = '{24'($urandom), 24'($urandom)};
        run_job(b, 0, 1, tmo, dd);
        checks++;
        if (tmo || dd != 1 || got_q.size() != 2) begin
            errors++; $display("FAIL start_while_busy tmo=%0d done=%0d count=%0d expected 0/1/2", tmo, dd, got_q.size());
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_psum(b, pix_tab[i])) begin
                errors++; $display("FAIL start_while_busy_result[%0d] got %h expected %h", i, got_q[i], ref_psum(b, pix_tab[i]));
            end
        end
    endtask

    task automatic test_reset_drain();
        bit ok, tmo; int dd, d0; logic [19:0] b;
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 8'd2; cfg_bias = 20'h00777;
        @(posedge clk); #1;
        start = 1'b0;
        send_pix(24'h030303, ok);
        send_pix(24'h040404, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b1 || pe_ifmap !== 24'h0 || bus.pix_ready !== 1'b0) begin
            errors++; $display("FAIL drain_reached ok=%0d busy=%b ifmap=%h rdy=%b expected 1/1/0/0",
                               ok, busy, pe_ifmap, bus.pix_ready);
        end
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, pe_en, bus.pix_ready, bus.out_valid, done, pe_phase, pe_psum_head, pe_ifmap, bus.out_psum} !== '0) begin
            errors++; $display("FAIL reset_in_drain busy=%b en=%b rdy=%b ov=%b done=%b ph=%0d head=%h ifm=%h psum=%h expected all 0",
                               busy, pe_en, bus.pix_ready, bus.out_valid, done, pe_phase, pe_psum_head, pe_ifmap, bus.out_psum);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != d0 || got_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_discard done_pulses=%0d results=%0d ov=%b expected 0/0/0",
                               done_cnt - d0, got_q.size(), bus.out_valid);
        end
        b = 20'($urandom);
        pix_tab = '{24'($urandom), 24'($urandom), 24'($urandom)};
        run_job(b, 1, 0, tmo, dd);
        checks++;
        if (tmo || dd != 1 || got_q.size() != 3) begin
            errors++; $display("FAIL fresh_run tmo=%0d done=%0d count=%0d expected 0/1/3", tmo, dd, got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_psum(b, pix_tab[i])) begin
                errors++; $display("FAIL fresh_result[%0d] got %h expected %h", i, got_q[i], ref_psum(b, pix_tab[i]));
            end
        end
    endtask

    task automatic test_random();
        bit tmo; int dd, n; logic [19:0] b;
        rdy_mode = 1;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 8);
            b = 20'($urandom);
            pix_tab.delete();
            repeat (n) pix_tab.push_back(24'($urandom));
            run_job(b, $urandom_range(0, 3), 0, tmo, dd);
            checks++;
            if (tmo || dd != 1 || got_q.size() != n) begin
                errors++; $display("FAIL random_run[%0d] tmo=%0d done=%0d count=%0d expected 0/1/%0d", j, tmo, dd, got_q.size(), n);
            end
            for (int i = 0; i < n && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== ref_psum(b, pix_tab[i])) begin
                    errors++; $display("FAIL random_result[%0d][%0d] got %h expected %h", j, i, got_q[i], ref_psum(b, pix_tab[i]));
                end
            end
        end
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (lat_err != 0 || inv_err != 0) begin
            errors++; $display("FAIL latency_and_enable latency_errors=%0d enable_errors=%0d expected 0/0", lat_err, inv_err);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single();
        test_bias_seq();
        test_stall();
        test_gaps();
        test_zero_len();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
